// File: rtl/core_clint_pkg.sv
// core_clint_pkg
// Shared constants for the core-local interruptor: window base, register
// offsets within the 256-byte window, and the offset-to-register decode.
package core_clint_pkg;

    localparam logic [31:0] CLINT_BASE        = 32'h0200_0000;

    localparam logic [7:0]  CLINT_MSIP        = 8'h00;
    localparam logic [7:0]  CLINT_MTIMECMP_LO = 8'h04;
    localparam logic [7:0]  CLINT_MTIMECMP_HI = 8'h08;
    localparam logic [7:0]  CLINT_MTIME_LO    = 8'h0C;
    localparam logic [7:0]  CLINT_MTIME_HI    = 8'h10;
    localparam logic [7:0]  CLINT_PRESC       = 8'h14;
    localparam logic [7:0]  CLINT_CTRL        = 8'h18;

    typedef enum logic [2:0] {
        REG_MSIP,
        REG_CMP_LO,
        REG_CMP_HI,
        REG_MTIME_LO,
        REG_MTIME_HI,
        REG_PRESC,
        REG_CTRL,
        REG_NONE
    } clint_reg_e;

    // Byte lanes addr[1:0] are ignored: every access is a whole word.
    function automatic clint_reg_e decode_reg(input logic [7:0] offset);
        clint_reg_e r;
        case ({offset[7:2], 2'b00})
            CLINT_MSIP:        r = REG_MSIP;
            CLINT_MTIMECMP_LO: r = REG_CMP_LO;
            CLINT_MTIMECMP_HI: r = REG_CMP_HI;
            CLINT_MTIME_LO:    r = REG_MTIME_LO;
            CLINT_MTIME_HI:    r = REG_MTIME_HI;
            CLINT_PRESC:       r = REG_PRESC;
            CLINT_CTRL:        r = REG_CTRL;
            default:           r = REG_NONE;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/core_clint_irq_sync.sv
// irq_sync
// Generic two-flop synchroniser for an asynchronous interrupt pin.
// No filtering: every level the pin holds across a sampling edge passes through.
// Ports:
//   clk_i    - destination clock
//   rst_i    - asynchronous active-low reset, clears both flops
//   async_i  - asynchronous input
//   sync_o   - synchronised output, 2 edges after the input
module irq_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic async_i,
    output logic sync_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
        end
    end

    assign sync_o = sync_q;

endmodule

// File: rtl/core_clint.sv
// core_clint
// Core-local interruptor on the data-memory bus: 64-bit mtime with
// prescaler, 64-bit mtimecmp, msip, and a synchronised external pin.
// Ports:
//   clk_i, rst_i          - core clock, asynchronous active-low reset
//   ce_i, we_i            - bus strobe and write enable
//   addr_i, wdata_i       - byte address and whole-word write data
//   sel_o                 - combinational window hit, muxes rdata_o over RAM
//   rdata_o               - combinational read data (0 when unselected/unmapped)
//   irq_ext_pin_i         - asynchronous external interrupt pin
//   irq_timer_o           - registered mtime >= mtimecmp
//   irq_software_o        - msip bit
//   irq_external_o        - synchronised external pin
module core_clint
    import core_clint_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = CLINT_BASE,
    parameter int          ADDR_WIDTH = 32,
    parameter int          DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  ce_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic                  sel_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    input  logic                  irq_ext_pin_i,
    output logic                  irq_timer_o,
    output logic                  irq_software_o,
    output logic                  irq_external_o
);

    clint_reg_e  reg_sel;
    logic        wr;
    logic        wr_msip, wr_cmp_lo, wr_cmp_hi, wr_mtime_lo, wr_mtime_hi;
    logic        wr_presc, wr_ctrl;
    logic        tick;
    logic        unused_addr;

    logic        msip_q;
    logic [63:0] mtimecmp_q;
    logic [63:0] mtime_q;
    logic [15:0] presc_q;
    logic        ctrl_en_q;
    logic [15:0] div_cnt_q;
    logic        irq_timer_q;

    assign sel_o       = ce_i && (addr_i[31:8] == BASE_ADDR[31:8]);
    assign reg_sel     = decode_reg(addr_i[7:0]);
    assign unused_addr = ^addr_i[1:0];

    assign wr          = sel_o && we_i;
    assign wr_msip     = wr && (reg_sel == REG_MSIP);
    assign wr_cmp_lo   = wr && (reg_sel == REG_CMP_LO);
    assign wr_cmp_hi   = wr && (reg_sel == REG_CMP_HI);
    assign wr_mtime_lo = wr && (reg_sel == REG_MTIME_LO);
    assign wr_mtime_hi = wr && (reg_sel == REG_MTIME_HI);
    assign wr_presc    = wr && (reg_sel == REG_PRESC);
    assign wr_ctrl     = wr && (reg_sel == REG_CTRL);

    assign tick = ctrl_en_q && (div_cnt_q == presc_q);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            msip_q      <= 1'b0;
            mtimecmp_q  <= 64'hFFFF_FFFF_FFFF_FFFF;
            mtime_q     <= 64'd0;
            presc_q     <= 16'd0;
            ctrl_en_q   <= 1'b1;
            div_cnt_q   <= 16'd0;
            irq_timer_q <= 1'b0;
        end else begin
            if (wr_msip)   msip_q           <= wdata_i[0];
            if (wr_cmp_lo) mtimecmp_q[31:0]  <= wdata_i[31:0];
            if (wr_cmp_hi) mtimecmp_q[63:32] <= wdata_i[31:0];
            if (wr_presc)  presc_q          <= wdata_i[15:0];
            if (wr_ctrl)   ctrl_en_q        <= wdata_i[0];

            // Reprogramming the divider restarts the period from zero.
            if (wr_presc || wr_ctrl) begin
                div_cnt_q <= 16'd0;
            end else if (ctrl_en_q) begin
                div_cnt_q <= tick ? 16'd0 : div_cnt_q + 16'd1;
            end

            // A bus write to either half wins over the tick, with no carry.
            if (wr_mtime_lo) begin
                mtime_q[31:0] <= wdata_i[31:0];
            end else if (wr_mtime_hi) begin
                mtime_q[63:32] <= wdata_i[31:0];
            end else if (tick) begin
                mtime_q <= mtime_q + 64'd1;
            end

            irq_timer_q <= (mtime_q >= mtimecmp_q);
        end
    end

    always_comb begin
        rdata_o = '0;
        if (sel_o) begin
            case (reg_sel)
                REG_MSIP:     rdata_o[0]    = msip_q;
                REG_CMP_LO:   rdata_o[31:0] = mtimecmp_q[31:0];
                REG_CMP_HI:   rdata_o[31:0] = mtimecmp_q[63:32];
                REG_MTIME_LO: rdata_o[31:0] = mtime_q[31:0];
                REG_MTIME_HI: rdata_o[31:0] = mtime_q[63:32];
                REG_PRESC:    rdata_o[15:0] = presc_q;
                REG_CTRL:     rdata_o[0]    = ctrl_en_q;
                default:      rdata_o       = '0;
            endcase
        end
    end

    assign irq_timer_o    = irq_timer_q;
    assign irq_software_o = msip_q;

    irq_sync u_ext_sync (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .async_i (irq_ext_pin_i),
        .sync_o  (irq_external_o)
    );

endmodule
